// File: rtl/bus_port_fifo.sv
// bus_port_fifo: single-clock show-ahead FIFO between a packet source and a bus.
// The head entry is always presented on D_pop while pndng is high. A write into
// a full FIFO is rejected unless a pop is accepted on the same edge. Rejected
// writes set a sticky overflow flag.
// Optional feature: define BUS_PORT_FIFO_DROP_CNT_EN to add an 8-bit saturating
// counter of rejected writes on output drop_cnt.
module bus_port_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_in,
  input  logic [width-1:0]           D_in,
  output logic                       full,
  output logic                       almost_full,
  output logic                       pndng,
  output logic [width-1:0]           D_pop,
  input  logic                       pop,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int PW = $clog2(depth);
  localparam int CW = $clog2(depth+1);

  logic [width-1:0] r_mem [depth];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_pndng;
  logic             w_pop_acc;
  logic             w_push_acc;
  logic             w_reject;

  // Flags come only from the registered occupancy; no path from push_in/pop.
  assign w_full      = (r_count == CW'(depth));
  assign w_pndng     = (r_count != '0);
  // A pop is only meaningful when something is stored. A write may use the slot
  // freed by a same-edge pop. Nothing is accepted while reset is held.
  assign w_pop_acc   = reset & pop & w_pndng;
  assign w_push_acc  = reset & push_in & (~w_full | w_pop_acc);
  assign w_reject    = reset & push_in & w_full & ~w_pop_acc;

  assign full        = w_full;
  assign almost_full = (r_count >= CW'(depth-1));
  assign pndng       = w_pndng;
  assign count       = r_count;
  assign overflow    = r_overflow;
  // Show-ahead head entry; forced to zero so stale memory never leaks out.
  assign D_pop       = w_pndng ? r_mem[r_rd_ptr] : '0;

  // Storage write; memory is deliberately not reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= D_in;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push_acc && !w_pop_acc) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_count <= r_count - CW'(1);
      end
      if (w_reject) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  assign drop_cnt = r_drop_cnt;

  // Count rejected writes, saturating at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_reject && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
`else
  // Drop counter not built; rejected writes are recorded only by overflow.
`endif

endmodule

// File: tb/tb_bus_port_fifo.sv
// tb_bus_port_fifo: directed self-checking bench for bus_port_fifo (width=16, depth=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_bus_port_fifo;

  logic        clk;
  logic        reset;
  logic        push_in;
  logic [15:0] D_in;
  logic        full;
  logic        almost_full;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic [3:0]  count;
  logic        overflow;
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int n_checks;
  int n_errors;

  bus_port_fifo #(.width(16), .depth(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_in    (push_in),
    .D_in       (D_in),
    .full       (full),
    .almost_full(almost_full),
    .pndng      (pndng),
    .D_pop      (D_pop),
    .pop        (pop),
    .count      (count),
    .overflow   (overflow)
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("pass %s: 0x%0h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    push_in  = 1'b1;   // must be ignored while reset is low
    pop      = 1'b1;
    D_in     = 16'hDEAD;

    step();
    step();
    check("rst_count",  32'(count), 32'd0);
    check("rst_pndng",  32'(pndng), 32'd0);
    check("rst_full",   32'(full), 32'd0);
    check("rst_afull",  32'(almost_full), 32'd0);
    check("rst_dpop",   32'(D_pop), 32'h0);
    check("rst_ovf",    32'(overflow), 32'd0);

    push_in = 1'b0;
    pop     = 1'b0;
    #2 reset = 1'b1;
    step();

    // Single push then pop.
    push_in = 1'b1; D_in = 16'h0301;
    step();
    push_in = 1'b0;
    check("p1_pndng", 32'(pndng), 32'd1);
    check("p1_dpop",  32'(D_pop), 32'h0301);
    check("p1_count", 32'(count), 32'd1);
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("p1_pop_pndng", 32'(pndng), 32'd0);
    check("p1_pop_dpop",  32'(D_pop), 32'h0);

    // Fill with 8 back-to-back pushes.
    for (int i = 0; i < 8; i++) begin
      push_in = 1'b1; D_in = 16'h0100 + 16'(i);
      step();
      if (i == 5) check("fill6_afull", 32'(almost_full), 32'd0);
      if (i == 6) begin
        check("fill7_afull", 32'(almost_full), 32'd1);
        check("fill7_full",  32'(full), 32'd0);
      end
    end
    push_in = 1'b0;
    check("fill8_full",  32'(full), 32'd1);
    check("fill8_count", 32'(count), 32'd8);

    // Drain; each pop exposes the next entry with no bubble.
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d_pndng", i), 32'(pndng), 32'd1);
      check($sformatf("drain%0d_dpop", i), 32'(D_pop), 32'h0100 + 32'(i));
      step();
    end
    pop = 1'b0;
    check("drain_empty", 32'(count), 32'd0);

    // Refill to full.
    for (int i = 0; i < 8; i++) begin
      push_in = 1'b1; D_in = 16'h0100 + 16'(i);
      step();
    end

    // Rejected write.
    push_in = 1'b1; D_in = 16'h0AAA; pop = 1'b0;
    step();
    push_in = 1'b0;
    check("ovf_flag",  32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_head",  32'(D_pop), 32'h0100);
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    check("ovf_drop",  32'(drop_cnt), 32'd1);
`endif

    // Push and pop together while full.
    push_in = 1'b1; D_in = 16'h0BBB; pop = 1'b1;
    step();
    push_in = 1'b0; pop = 1'b0;
    check("fpp_count", 32'(count), 32'd8);
    check("fpp_full",  32'(full), 32'd1);
    check("fpp_ovf",   32'(overflow), 32'd1);
    check("fpp_head",  32'(D_pop), 32'h0101);
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    check("fpp_drop",  32'(drop_cnt), 32'd1);
`endif
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fpp_rd%0d", i), 32'(D_pop), (i == 7) ? 32'h0BBB : 32'h0101 + 32'(i));
      step();
    end
    pop = 1'b0;
    check("fpp_empty", 32'(pndng), 32'd0);

    // Push and pop together while empty: pop ignored.
    push_in = 1'b1; D_in = 16'h0505; pop = 1'b1;
    step();
    push_in = 1'b0; pop = 1'b0;
    check("epp_count", 32'(count), 32'd1);
    check("epp_dpop",  32'(D_pop), 32'h0505);
    pop = 1'b1;
    step();
    check("epp_pop_count", 32'(count), 32'd0);
    step();   // pop on empty alone
    pop = 1'b0;
    check("epop_count", 32'(count), 32'd0);
    check("epop_pndng", 32'(pndng), 32'd0);
    check("epop_dpop",  32'(D_pop), 32'h0);

    // Asynchronous reset mid-operation with 5 entries.
    for (int i = 0; i < 5; i++) begin
      push_in = 1'b1; D_in = 16'h0600 + 16'(i);
      step();
    end
    push_in = 1'b0;
    check("ar_pre_count", 32'(count), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("ar_count", 32'(count), 32'd0);
    check("ar_pndng", 32'(pndng), 32'd0);
    check("ar_ovf",   32'(overflow), 32'd0);
    check("ar_dpop",  32'(D_pop), 32'h0);
`ifdef BUS_PORT_FIFO_DROP_CNT_EN
    check("ar_drop",  32'(drop_cnt), 32'd0);
`endif
    #1 reset = 1'b1;
    step();
    push_in = 1'b1; D_in = 16'h0777;
    step();
    push_in = 1'b0;
    check("post_rst_dpop",  32'(D_pop), 32'h0777);
    check("post_rst_count", 32'(count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
